// File: rtl/bram_arb_pkg.sv
// Shared types and default widths for the BRAM port arbiter.
package bram_arb_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 10;
   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_RD_LATENCY = 1;
   localparam int unsigned DEF_MAX_WAIT   = 8;
   localparam int unsigned WAIT_W         = 8;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_sel_t;

   typedef struct packed {
      logic      valid;
      port_sel_t port;
      logic      we;
   } rsp_tag_t;

endpackage

// File: rtl/bram_arb_rsp_pipe.sv
// Completion tag delay line matching the BRAM read latency; cleared
// synchronously while rst_n is low.
module bram_arb_rsp_pipe
   import bram_arb_pkg::*;
#(
   parameter int unsigned RD_LATENCY = DEF_RD_LATENCY
) (
   input  logic     clk,
   input  logic     rst_n,
   input  rsp_tag_t tag_in,
   output rsp_tag_t tag_out
);

   rsp_tag_t [RD_LATENCY-1:0] stage;

   if (RD_LATENCY == 1) begin : g_one
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            stage <= '0;
         end else begin
            stage[0] <= tag_in;
         end
      end
   end else begin : g_multi
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            stage <= '0;
         end else begin
            stage <= {stage[RD_LATENCY-2:0], tag_in};
         end
      end
   end

   assign tag_out = stage[RD_LATENCY-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-port arbiter/sequencer for a single-port fixed-latency BRAM, B priority
// with port A anti-starvation. Optional counters under BRAM_ARB_STATS_EN.
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned RD_LATENCY = DEF_RD_LATENCY,
   parameter int unsigned MAX_WAIT   = DEF_MAX_WAIT
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic                    a_req_valid,
   output logic                    a_req_ready,
   input  logic                    a_req_we,
   input  logic [ADDR_WIDTH-1:0]   a_req_addr,
   input  logic [DATA_WIDTH-1:0]   a_req_wdata,
   input  logic [DATA_WIDTH/8-1:0] a_req_wstrb,
   output logic                    a_rsp_valid,
   output logic                    a_rsp_we,
   output logic [DATA_WIDTH-1:0]   a_rsp_rdata,
   input  logic                    b_req_valid,
   output logic                    b_req_ready,
   input  logic                    b_req_we,
   input  logic [ADDR_WIDTH-1:0]   b_req_addr,
   input  logic [DATA_WIDTH-1:0]   b_req_wdata,
   input  logic [DATA_WIDTH/8-1:0] b_req_wstrb,
   output logic                    b_rsp_valid,
   output logic                    b_rsp_we,
   output logic [DATA_WIDTH-1:0]   b_rsp_rdata,
   output logic                    bram_en,
   output logic [DATA_WIDTH/8-1:0] bram_we,
   output logic [ADDR_WIDTH-1:0]   bram_addr,
   output logic [DATA_WIDTH-1:0]   bram_wdata,
   input  logic [DATA_WIDTH-1:0]   bram_rdata
`ifdef BRAM_ARB_STATS_EN
   ,
   output logic [31:0]             stat_a_grants,
   output logic [31:0]             stat_b_grants,
   output logic [31:0]             stat_a_forced
`endif
);

   logic [WAIT_W-1:0] a_wait;
   logic              a_forced;
   logic              grant_a;
   logic              grant_b;
   rsp_tag_t          tag_in;
   rsp_tag_t          tag_out;

   // Forced A beats B beats plain A; nothing is granted while in reset.
   always_comb begin
      a_forced = 1'b0;
      grant_a  = 1'b0;
      grant_b  = 1'b0;
      if (ARESETN) begin
         if (a_req_valid && (a_wait == WAIT_W'(MAX_WAIT))) begin
            a_forced = 1'b1;
            grant_a  = 1'b1;
         end else if (b_req_valid) begin
            grant_b = 1'b1;
         end else if (a_req_valid) begin
            grant_a = 1'b1;
         end
      end
   end

   assign a_req_ready = grant_a;
   assign b_req_ready = grant_b;

   always_comb begin
      bram_en    = grant_a | grant_b;
      bram_we    = '0;
      bram_addr  = '0;
      bram_wdata = '0;
      tag_in     = '0;
      if (grant_b) begin
         bram_we    = b_req_we ? b_req_wstrb : '0;
         bram_addr  = b_req_addr;
         bram_wdata = b_req_wdata;
         tag_in     = '{valid: 1'b1, port: PORT_B, we: b_req_we};
      end else if (grant_a) begin
         bram_we    = a_req_we ? a_req_wstrb : '0;
         bram_addr  = a_req_addr;
         bram_wdata = a_req_wdata;
         tag_in     = '{valid: 1'b1, port: PORT_A, we: a_req_we};
      end
   end

   // Counts consecutive denied cycles of a pending A request, saturating.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         a_wait <= '0;
      end else if (!a_req_valid || grant_a) begin
         a_wait <= '0;
      end else if (a_wait != WAIT_W'(MAX_WAIT)) begin
         a_wait <= a_wait + WAIT_W'(1);
      end
   end

   bram_arb_rsp_pipe #(
      .RD_LATENCY(RD_LATENCY)
   ) u_rsp_pipe (
      .clk    (ACLK),
      .rst_n  (ARESETN),
      .tag_in (tag_in),
      .tag_out(tag_out)
   );

   // Steer the completion to its owner; write completions carry zero data.
   always_comb begin
      a_rsp_valid = 1'b0;
      a_rsp_we    = 1'b0;
      a_rsp_rdata = '0;
      b_rsp_valid = 1'b0;
      b_rsp_we    = 1'b0;
      b_rsp_rdata = '0;
      if (ARESETN && tag_out.valid) begin
         if (tag_out.port == PORT_B) begin
            b_rsp_valid = 1'b1;
            b_rsp_we    = tag_out.we;
            b_rsp_rdata = tag_out.we ? '0 : bram_rdata;
         end else begin
            a_rsp_valid = 1'b1;
            a_rsp_we    = tag_out.we;
            a_rsp_rdata = tag_out.we ? '0 : bram_rdata;
         end
      end
   end

`ifdef BRAM_ARB_STATS_EN
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         stat_a_grants <= '0;
         stat_b_grants <= '0;
         stat_a_forced <= '0;
      end else begin
         if (grant_a) stat_a_grants <= stat_a_grants + 32'd1;
         if (grant_b) stat_b_grants <= stat_b_grants + 32'd1;
         if (a_forced) stat_a_forced <= stat_a_forced + 32'd1;
      end
   end
`endif

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Two-requester arbiter and sequencer for a single-port BRAM with a fixed read latency. It sits between the AXI-Lite register front end (port A) and a fabric-side streaming requester such as a capture writer (port B), and drives the BRAM's native port. Port B has priority; an anti-starvation counter guarantees port A forward progress. Each accepted access returns exactly one completion pulse on its owning port after the BRAM read latency.

## Interface
- ADDR_WIDTH, 10, BRAM word-address width
- DATA_WIDTH, 32, data width; multiple of 8
- RD_LATENCY, 1, BRAM read latency in cycles; legal values 1 or 2
- MAX_WAIT, 8, consecutive cycles port A may be denied while valid before it is forced a grant; range 1..255

Ports:
- ACLK  in  1  sole clock
- ARESETN  in  1  synchronous, active-low reset
- a_req_valid / b_req_valid  in  1  request valid
- a_req_ready / b_req_ready  out  1  grant; request accepted when valid && ready
- a_req_we / b_req_we  in  1  1 = write, 0 = read
- a_req_addr / b_req_addr  in  ADDR_WIDTH  word address
- a_req_wdata / b_req_wdata  in  DATA_WIDTH  write data
- a_req_wstrb / b_req_wstrb  in  DATA_WIDTH/8  byte enables
- a_rsp_valid / b_rsp_valid  out  1  completion pulse; no backpressure
- a_rsp_we / b_rsp_we  out  1  completion belongs to a write
- a_rsp_rdata / b_rsp_rdata  out  DATA_WIDTH  read data; 0 for write completions
- bram_en  out  1  BRAM enable
- bram_we  out  DATA_WIDTH/8  BRAM byte write enables
- bram_addr  out  ADDR_WIDTH  BRAM address
- bram_wdata  out  DATA_WIDTH  BRAM write data
- bram_rdata  in  DATA_WIDTH  BRAM read data, valid RD_LATENCY cycles after bram_en

## Operation
- Grant is at most one per cycle. Both ports may be granted on back-to-back cycles, so the BRAM issue rate is 1 access per cycle.
- Priority rules, in order:
  - If a_wait == MAX_WAIT and a_req_valid, grant A.
  - Else if b_req_valid, grant B.
  - Else if a_req_valid, grant A.
- a_wait counter behaviour:
  - Increments when a_req_valid && !a_req_ready.
  - Clears on an A grant or when a_req_valid = 0.
  - Saturates at MAX_WAIT.
- BRAM issue on grant: bram_en=1, bram_addr/bram_wdata from the granted port, bram_we = we ? wstrb : 0.
- A write with wstrb=0 still consumes a slot and produces a completion.
- Completion pipeline:
  - Each grant pushes {valid, port, we} into a RD_LATENCY-deep delay line.
  - At the output, the owning rsp_valid pulses for one cycle, with rsp_rdata=bram_rdata for reads and 0 for writes.
  - The non-owning port sees rsp_valid=0 and rdata=0.
- Requesters must not drop valid or change payload while valid && !ready.

## Timing
- Reset values (while ARESETN=0 and on the first cycle after it):
  - All *_ready, bram_en, bram_we, *_rsp_valid, *_rsp_we = 0.
  - rdata and address/data outputs = 0.
  - a_wait = 0; delay line cleared.
- Reset mid-operation drops all in-flight completions. No rsp_valid pulses for them after reset.
- *_req_ready and the bram_* outputs are combinational from the req_valid signals and registered a_wait. Requesters' valid must not depend on ready.
- Latency: accept at cycle T gives rsp_valid at T+RD_LATENCY.
- Read-after-write to the same address on consecutive grants returns the new data. This relies on the BRAM being configured for write-first.
- Worst-case A latency while B is continuously valid: MAX_WAIT+1 cycles from valid to grant.

## Configuration
- BRAM_ARB_STATS_EN defined adds three outputs, all 32-bit and all cleared on reset:
  - stat_a_grants: count of A grants.
  - stat_b_grants: count of B grants.
  - stat_a_forced: count of grants forced by a_wait == MAX_WAIT.
- The counters wrap modulo 2^32.
- BRAM_ARB_STATS_EN undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

## Structure
- Package bram_arb_pkg holds:
  - enum port_sel_t {PORT_A, PORT_B}.
  - Typedef rsp_tag_t {valid, port_sel_t port, we}.
  - Default width constants.
- Sub-module bram_arb_rsp_pipe: parameterised RD_LATENCY delay line of rsp_tag_t, with synchronous clear on ARESETN low.

## Test plan
- Port A alone reads addr 0x004 after port A writes 0x1234_5678 there (wstrb=4'hF). Required: a_rsp_valid 1 cycle after each accept; read rdata = 0x1234_5678; b_rsp_valid never asserted.
- Both ports valid continuously, MAX_WAIT=8. Required: B granted 8 cycles, then A granted on the 9th cycle; the pattern repeats; stat_a_forced increments once per forced grant when BRAM_ARB_STATS_EN is defined.
- Simultaneous single requests (A read 0x010, B write 0xDEAD_BEEF to 0x010). Required: B granted first, A the next cycle; A reads 0xDEAD_BEEF.
- Byte-strobe write of 0xAABB_CCDD with wstrb=4'b0101 over 0x0000_0000. Required: readback 0x00BB_00DD. A wstrb=0 write still returns one completion with rsp_we=1.
- RD_LATENCY=2, back-to-back reads from alternating ports. Required: completions arrive in issue order at T+2 with the correct port steering.
- Deassert ARESETN for 1 cycle with 2 reads in flight. Required: no rsp_valid pulses follow; all outputs are 0 during reset; a_wait = 0 afterwards.
